irq_daisy_ctrl: RTL and testbench

Parametrised Z80 mode-2 interrupt controller for the Einstein core. It replaces the single hard-wired keyboard interrupt latch (mask bit, fixed vector 0x0E) with NCH prioritised channels, one per source: keyboard, ADC, fire button, and spares. Each channel has edge or level qualification, a mask bit, a pending latch and an in-service bit. The block sits on the CPU bus next to the CTC and joins the IEI/IEO daisy chain, so CTC and controller interrupts nest correctly.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_daisy_ctrl_if.sv | 29 ++
 rtl/irq_chan.sv | 44 ++++
 rtl/irq_daisy_ctrl.sv | 127 ++++++++++++
 tb/tb_irq_daisy_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the Einstein mode-2 interrupt controller: register map,
// default vector base and channel assignment.
package irq_pkg;

  localparam logic ADDR_MASK = 1'b0;
  localparam logic ADDR_PEND = 1'b1;

  localparam logic [7:0] VEC_BASE_DEFAULT = 8'h08;

  localparam int unsigned CH_KB   = 0;
  localparam int unsigned CH_ADC  = 1;
  localparam int unsigned CH_FIRE = 2;

  // Mode-2 vectors must be even; bit 0 is forced low regardless of base.
  function automatic logic [7:0] chan_vector(input logic [7:0] base, input logic [2:0] idx);
    logic [7:0] v;
    v = base + {4'b0000, idx, 1'b0};
    return {v[7:1], 1'b0};
  endfunction

endpackage

// File: rtl/irq_daisy_ctrl_if.sv
// CPU bus, INTA/RETI strobes and daisy-chain signals of the interrupt controller.
interface irq_daisy_ctrl_if;

  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       m1_n;
  logic       iorq_n;
  logic       reti;
  logic       iei;
  logic       ieo;
  logic       int_n;
  logic [7:0] vec;
  logic       vec_oe;

  modport master (
    output cs_n, wr_n, rd_n, addr, din, m1_n, iorq_n, reti, iei,
    input  dout, ieo, int_n, vec, vec_oe
  );

  modport slave (
    input  cs_n, wr_n, rd_n, addr, din, m1_n, iorq_n, reti, iei,
    output dout, ieo, int_n, vec, vec_oe
  );

endinterface

// File: rtl/irq_chan.sv
// One interrupt channel: input sample + edge-detect stage and the pending latch
// with its set/clear arbitration.
module irq_chan #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic irq_in,
  input  logic mask,
  input  logic w1c,
  input  logic inta_clr,
  output logic pend
);

  logic irq_q;
  logic irq_prev_q;
  logic pend_q;
  logic pend_d;
  logic event_hit;

  // Later assignments win: INTA clear beats an event, an event beats W1C.
  always_comb begin
    event_hit = EDGE ? (irq_q & ~irq_prev_q) : irq_q;
    pend_d    = pend_q;
    if (w1c) pend_d = 1'b0;
    if (event_hit && !mask) pend_d = 1'b1;
    if (inta_clr) pend_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      irq_q      <= 1'b0;
      irq_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      irq_q      <= irq_in;
      irq_prev_q <= irq_q;
      pend_q     <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/irq_daisy_ctrl.sv
// Z80 mode-2 prioritised interrupt controller joining the IEI/IEO daisy chain.
// Holds mask, in-service bits, INTA vectoring, RETI handling and the register mux.
module irq_daisy_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned    NCH      = 4,
  parameter logic [7:0]     VEC_BASE = VEC_BASE_DEFAULT,
  parameter logic [NCH-1:0] EDGE     = '1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [NCH-1:0]   irq_in,
  irq_daisy_ctrl_if.slave  bus
);

  logic [NCH-1:0] mask_q;
  logic [NCH-1:0] ins_q;
  logic [NCH-1:0] ins_d;
  logic [NCH-1:0] pend_vec;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] first_oh;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] reti_oh;
  logic [2:0]     grant_idx;
  logic           any_elig;
  logic           reg_wr;
  logic           reg_rd;
  logic           mask_wr;
  logic           pend_wr;
  logic           inta;
  logic           inta_q;
  logic           grant_go;
  logic           grant_q;
  logic [7:0]     vec_q;

  assign reg_wr  = ~bus.cs_n & ~bus.wr_n;
  assign reg_rd  = ~bus.cs_n & ~bus.rd_n;
  assign mask_wr = reg_wr & (bus.addr == ADDR_MASK);
  assign pend_wr = reg_wr & (bus.addr == ADDR_PEND);
  assign inta    = ~bus.m1_n & ~bus.iorq_n;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    irq_chan #(
      .EDGE (EDGE[i])
    ) u_chan (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .irq_in   (irq_in[i]),
      .mask     (mask_q[i]),
      .w1c      (pend_wr & bus.din[i]),
      .inta_clr (grant_oh[i]),
      .pend     (pend_vec[i])
    );
  end

  // A channel is blocked by any in-service channel of equal or higher priority.
  always_comb begin
    logic blocked;
    logic found;
    logic ins_found;
    blocked   = 1'b0;
    found     = 1'b0;
    ins_found = 1'b0;
    elig      = '0;
    first_oh  = '0;
    reti_oh   = '0;
    grant_idx = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      blocked = blocked | ins_q[i];
      elig[i] = pend_vec[i] & ~blocked;
      if (elig[i] && !found) begin
        found       = 1'b1;
        first_oh[i] = 1'b1;
        grant_idx   = 3'(i);
      end
      if (ins_q[i] && !ins_found) begin
        ins_found  = 1'b1;
        reti_oh[i] = 1'b1;
      end
    end
  end

  assign any_elig = |elig;
  assign grant_go = inta & ~inta_q & bus.iei & any_elig;
  assign grant_oh = grant_go ? first_oh : '0;

  always_comb begin
    ins_d = ins_q;
    if (bus.reti && bus.iei) ins_d = ins_d & ~reti_oh;
    ins_d = ins_d | grant_oh;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mask_q  <= '1;
      ins_q   <= '0;
      inta_q  <= 1'b0;
      grant_q <= 1'b0;
      vec_q   <= 8'h00;
    end else begin
      if (mask_wr) mask_q <= bus.din[NCH-1:0];
      ins_q  <= ins_d;
      inta_q <= inta;
      if (grant_go) begin
        grant_q <= 1'b1;
        vec_q   <= chan_vector(VEC_BASE, grant_idx);
      end else if (!inta) begin
        grant_q <= 1'b0;
      end
    end
  end

  // The M1 term keeps lower devices off the chain while INTA priority settles.
  assign bus.int_n  = ~(bus.iei & any_elig);
  assign bus.ieo    = bus.iei & ~(|ins_q) & ~(~bus.m1_n & any_elig);
  assign bus.vec    = vec_q;
  assign bus.vec_oe = grant_q & inta & ~reset;

  always_comb begin
    bus.dout = 8'h00;
    if (reg_rd) begin
      if (bus.addr == ADDR_MASK) bus.dout = 8'(mask_q);
      else                       bus.dout = 8'({ins_q, pend_vec});
    end
  end

endmodule

// File: tb/tb_irq_daisy_ctrl.sv
// Directed test-plan steps followed by random traffic, each cycle compared
// against a behavioural model of the controller.
module tb_irq_daisy_ctrl;

  localparam logic [3:0] TB_EDGE = 4'b1110;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  int         n_cmp;
  int         n_bad;

  irq_daisy_ctrl_if bus();

  irq_daisy_ctrl #(
    .NCH      (4),
    .VEC_BASE (8'h08),
    .EDGE     (TB_EDGE)
  ) dut (
    .clk_sys (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state, in the terms the controller is described with.
  bit [3:0] m_mask, m_pend, m_ins, m_smp, m_smp_prev;
  bit       m_inta_prev, m_grant;
  bit [7:0] m_vec;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  // Lowest channel with a pending request and no in-service channel at or above it.
  function automatic int low_elig();
    for (int i = 0; i < 4; i++) begin
      bit ok;
      ok = m_pend[i];
      for (int j = 0; j <= i; j++) if (m_ins[j]) ok = 1'b0;
      if (ok) return i;
    end
    return -1;
  endfunction

  task automatic model_check();
    bit any, inta, rd;
    bit [7:0] exp_dout;
    any  = (low_elig() >= 0);
    inta = !bus.m1_n && !bus.iorq_n;
    rd   = !bus.cs_n && !bus.rd_n;
    exp_dout = !rd ? 8'h00 : (bus.addr ? {m_ins, m_pend} : {4'h0, m_mask});
    chk("int_n", bus.int_n, 8'(!(bus.iei && any)));
    chk("ieo", bus.ieo, 8'(bus.iei && m_ins == 0 && !(!bus.m1_n && any)));
    chk("vec_oe", bus.vec_oe, 8'(m_grant && inta && !reset));
    chk("vec", bus.vec, m_vec);
    chk("dout", bus.dout, exp_dout);
  endtask

  task automatic model_step();
    bit [3:0] n_pend, n_ins, n_mask;
    bit       inta, ev;
    int       k;
    if (reset) begin
      m_mask = 4'hF; m_pend = 0; m_ins = 0; m_smp = 0; m_smp_prev = 0;
      m_inta_prev = 0; m_grant = 0; m_vec = 0;
      return;
    end
    n_pend = m_pend; n_ins = m_ins; n_mask = m_mask;
    for (int i = 0; i < 4; i++) begin
      ev = TB_EDGE[i] ? (m_smp[i] && !m_smp_prev[i]) : m_smp[i];
      if (!bus.cs_n && !bus.wr_n && bus.addr && bus.din[i]) n_pend[i] = 0;
      if (ev && !m_mask[i]) n_pend[i] = 1;
    end
    if (!bus.cs_n && !bus.wr_n && !bus.addr) n_mask = bus.din[3:0];
    if (bus.reti && bus.iei)
      for (int i = 0; i < 4; i++) if (m_ins[i]) begin n_ins[i] = 0; break; end
    inta = !bus.m1_n && !bus.iorq_n;
    k = low_elig();
    if (inta && !m_inta_prev && bus.iei && k >= 0) begin
      m_vec = 8'(8'h08 + 2 * k);
      n_pend[k] = 0;
      n_ins[k] = 1;
      m_grant = 1;
    end else if (!inta) begin
      m_grant = 0;
    end
    m_pend = n_pend; m_ins = n_ins; m_mask = n_mask;
    m_smp_prev = m_smp; m_smp = irq_in; m_inta_prev = inta;
  endtask

  task automatic cycle();
    #1;
    model_check();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus.cs_n = 0; bus.wr_n = 0; bus.addr = a; bus.din = d;
    cycle();
    bus.cs_n = 1; bus.wr_n = 1;
  endtask

  task automatic rd(input logic a, input logic [7:0] exp_v);
    bus.cs_n = 0; bus.rd_n = 0; bus.addr = a;
    #1;
    chk(a ? "rd_pend" : "rd_mask", bus.dout, exp_v);
    bus.cs_n = 1; bus.rd_n = 1;
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1;
    cycle();
    irq_in[ch] = 1'b0;
  endtask

  task automatic do_reti();
    bus.reti = 1'b1;
    cycle();
    bus.reti = 1'b0;
  endtask

  task automatic do_inta(input logic [7:0] exp_vec, input bit exp_oe);
    bus.m1_n = 0; bus.iorq_n = 0;
    #1;
    chk("inta_ieo", bus.ieo, 8'h00);
    cycle();
    #1;
    chk("inta_oe", bus.vec_oe, 8'(exp_oe));
    if (exp_oe) chk("inta_vec", bus.vec, exp_vec);
    cycle();
    bus.m1_n = 1; bus.iorq_n = 1;
    cycle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1; irq_in = 0;
    bus.cs_n = 1; bus.wr_n = 1; bus.rd_n = 1; bus.addr = 0; bus.din = 0;
    bus.m1_n = 1; bus.iorq_n = 1; bus.reti = 0; bus.iei = 1;
    model_step();
    @(posedge clk);
    #2;
    wait_n(2);
    reset = 0;
    wait_n(1);

    // Reset state
    chk("rst_int_n", bus.int_n, 8'h01);
    chk("rst_ieo", bus.ieo, 8'h01);
    chk("rst_vec", bus.vec, 8'h00);
    rd(0, 8'h0F);
    rd(1, 8'h00);

    // Masking
    pulse(irq_pkg::CH_KB);
    wait_n(3);
    chk("masked_int_n", bus.int_n, 8'h01);
    rd(1, 8'h00);
    wr(0, 8'h00);
    pulse(irq_pkg::CH_KB);
    chk("lat1_int_n", bus.int_n, 8'h01);
    cycle();
    chk("lat2_int_n", bus.int_n, 8'h00);
    wr(1, 8'h01);
    rd(1, 8'h00);

    // Priority
    pulse(1); pulse(3); wait_n(2);
    chk("prio_int_n", bus.int_n, 8'h00);
    do_inta(8'h0A, 1);
    rd(1, 8'h28);
    chk("prio_ieo", bus.ieo, 8'h00);
    do_reti();
    rd(1, 8'h08);
    do_inta(8'h0E, 1);
    do_reti();
    rd(1, 8'h00);

    // Nesting
    pulse(2); wait_n(2);
    do_inta(8'h0C, 1);
    pulse(3); wait_n(2);
    chk("nest_blk_int_n", bus.int_n, 8'h01);
    pulse(0); wait_n(2);
    chk("nest_int_n", bus.int_n, 8'h00);
    do_inta(8'h08, 1);
    rd(1, 8'h58);
    do_reti();
    rd(1, 8'h48);
    do_reti();
    rd(1, 8'h08);
    do_inta(8'h0E, 1);
    do_reti();
    rd(1, 8'h00);

    // Daisy chain
    bus.iei = 0;
    pulse(0); wait_n(2);
    chk("dc_int_n", bus.int_n, 8'h01);
    chk("dc_ieo", bus.ieo, 8'h00);
    do_inta(8'h00, 0);
    rd(1, 8'h01);
    bus.iei = 1;
    do_inta(8'h08, 1);
    rd(1, 8'h10);
    bus.iei = 0;
    do_reti();
    rd(1, 8'h10);
    bus.iei = 1;
    do_reti();
    rd(1, 8'h00);

    // Level vs edge
    irq_in[0] = 1; wait_n(3);
    rd(1, 8'h01);
    wr(1, 8'h01);
    rd(1, 8'h01);
    irq_in[1] = 1; wait_n(3);
    rd(1, 8'h03);
    wr(1, 8'h02);
    wait_n(2);
    rd(1, 8'h01);
    irq_in = 0; wait_n(2);
    wr(1, 8'h03);
    rd(1, 8'h00);

    // Event and W1C in the same cycle
    pulse(1); wait_n(2);
    irq_in[1] = 1; cycle(); irq_in[1] = 0;
    bus.cs_n = 0; bus.wr_n = 0; bus.addr = 1; bus.din = 8'h02;
    cycle();
    bus.cs_n = 1; bus.wr_n = 1;
    rd(1, 8'h02);
    wr(1, 8'h02);
    rd(1, 8'h00);

    // Reset mid-INTA
    pulse(2); wait_n(2);
    bus.m1_n = 0; bus.iorq_n = 0;
    cycle();
    #1;
    chk("pre_rst_oe", bus.vec_oe, 8'h01);
    chk("pre_rst_vec", bus.vec, 8'h0C);
    reset = 1;
    #1;
    chk("rst_oe_now", bus.vec_oe, 8'h00);
    cycle();
    bus.m1_n = 1; bus.iorq_n = 1; reset = 0;
    cycle();
    chk("post_rst_int_n", bus.int_n, 8'h01);
    chk("post_rst_vec", bus.vec, 8'h00);
    rd(0, 8'h0F);
    rd(1, 8'h00);

    // Random traffic
    wr(0, 8'($urandom_range(0, 15)));
    for (int c = 0; c < 800; c++) begin
      irq_in      = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus.iei     = ($urandom_range(0, 9) != 0);
      bus.cs_n    = ($urandom_range(0, 3) != 0);
      bus.wr_n    = 1'($urandom_range(0, 1));
      bus.rd_n    = 1'($urandom_range(0, 1));
      bus.addr    = 1'($urandom_range(0, 1));
      bus.din     = 8'($urandom);
      bus.m1_n    = ($urandom_range(0, 2) != 0);
      bus.iorq_n  = bus.m1_n ? 1'b1 : 1'($urandom_range(0, 1));
      bus.reti    = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 249) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
